branch_resolve_unit: RTL

Parametrised branch resolution unit for the RV32 core: decodes all six conditional-branch funct3 codes (BEQ, BNE, BLT, BGE, BLTU, BGEU), compares the two operands, and registers the taken/not-taken outcome. It also maintains a PC-indexed table of 2-bit saturating counters that feeds a taken prediction back to fetch, and flags mispredictions so the PC-source logic can redirect. It sits between the register-read stage and the PC-source mux.

---
 rtl/branch_pkg.sv | 33 +++
 rtl/branch_compare.sv | 39 +++
 rtl/branch_resolve_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: funct3 codes,
// 2-bit saturating counter encodings and the predictor FSM states.
package branch_pkg;

  // Conditional-branch funct3 codes (RV32I)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Saturating counter encodings; the MSB is the taken prediction
  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bru_state_e;

  // Next counter value after a resolved branch, saturating at both ends
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator: funct3 + operands -> taken.
// funct3 010/011 are not branches and are flagged illegal (never taken).
module branch_compare
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // Select the branch condition for the decoded funct3
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: resolves conditional branches with one cycle of
// latency and, when BRANCH_PREDICT_EN is defined, keeps a PC-indexed table
// of 2-bit saturating counters that predicts taken/not-taken for fetch.
// Without BRANCH_PREDICT_EN the unit predicts static not-taken.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_DEPTH   = 64,
  parameter int BHT_IDX_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [2:0]      res_funct3,
  input  logic [XLEN-1:0] res_rs1,
  input  logic [XLEN-1:0] res_rs2,
  input  logic            res_pred,
  output logic            out_valid,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal
);

  logic cmp_taken;
  logic cmp_illegal;
  logic accept;

  // Only the index field of the PCs feeds the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, res_pc};

  branch_compare #(
    .XLEN(XLEN)
  ) u_compare (
    .funct3  (res_funct3),
    .rs1     (res_rs1),
    .rs2     (res_rs2),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign accept = ready && res_valid;

  // Result registers: one-cycle strobe per accepted request, cleared otherwise
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
    end else begin
      out_valid      <= accept;
      out_taken      <= accept && cmp_taken;
      out_illegal    <= accept && cmp_illegal;
      out_mispredict <= accept && !cmp_illegal && (cmp_taken ^ res_pred);
    end
  end

`ifdef BRANCH_PREDICT_EN
  localparam int IDX_W = $clog2(BHT_DEPTH);

  bru_state_e       state_q;
  bru_state_e       state_d;
  logic [IDX_W-1:0] init_idx_q;
  logic [IDX_W-1:0] res_idx;
  logic [IDX_W-1:0] pred_idx;
  // NOTE: the table has no reset; the INIT sweep writes every entry before use.
  logic [1:0]       bht [BHT_DEPTH];

  assign res_idx  = res_pc[BHT_IDX_LSB +: IDX_W];
  assign pred_idx = pred_pc[BHT_IDX_LSB +: IDX_W];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next state and ready: leave INIT once the last entry has been written
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      INIT: if (init_idx_q == IDX_W'(BHT_DEPTH - 1)) state_d = RUN;
      RUN:  ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  // Init sweep index, restarted from entry 0 on every reset
  always_ff @(posedge clk) begin
    if (rst)                  init_idx_q <= '0;
    else if (state_q == INIT) init_idx_q <= init_idx_q + 1'b1;
  end

  // Single table write port: sweep in INIT, counter update on legal resolves
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      bht[init_idx_q] <= CTR_RESET;
    end else if (!rst && accept && !cmp_illegal) begin
      bht[res_idx] <= ctr_next(bht[res_idx], cmp_taken);
    end
  end

  // Lookup reads the stored value; a same-cycle update is not bypassed
  assign pred_taken = (state_q == RUN) && bht[pred_idx][1];
`else
  localparam int unused_bht_cfg = BHT_DEPTH + BHT_IDX_LSB;

  logic ready_q;

  // Ready one cycle after reset; nothing to initialise without a table
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign ready      = ready_q;
  assign pred_taken = 1'b0;
`endif

endmodule
